// File: rtl/ddr_output_framer_if.sv
// Input stream bundle for the DDR output framer.
// A source (master) presents framed 2*WIDTH-bit words; the framer (slave)
// accepts them whenever in_valid and in_ready are both high.
//   in_valid : word on in_data/in_last is valid
//   in_ready : framer FIFO can take a word this clock
//   in_data  : [WIDTH-1:0] rising-edge lane, [2*WIDTH-1:WIDTH] falling-edge lane
//   in_last  : final word of the frame
interface ddr_output_framer_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   in_data;
    logic                 in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/ddr_output_framer.sv
// Transmit framer feeding ganged DDR output buffers.
// Buffers framed words in a FIFO, then sends each frame as a fixed preamble
// followed by one word per clock on the rising/falling lane pair. Gaps carry
// IDLE_WORD. If the FIFO runs dry mid-frame the frame is aborted (underrun)
// and the rest of it is discarded as it arrives.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_if       : input stream (slave side)
//   dout0/dout1 : rising-edge / falling-edge lane
//   tx_en       : preamble or frame data is being driven
//   busy        : framer state is not IDLE
//   underrun    : one-clock pulse when a frame is aborted
//   fifo_level  : current FIFO occupancy
module ddr_output_framer #(
    parameter int                     WIDTH           = 16,
    parameter int                     FIFO_DEPTH      = 16,
    parameter int                     START_THRESH    = 8,
    parameter int                     PREAMBLE_CYCLES = 2,
    parameter logic [2*WIDTH-1:0]     PREAMBLE_WORD   = 32'h5555_5555,
    parameter logic [2*WIDTH-1:0]     IDLE_WORD       = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ddr_output_framer_if.slave            in_if,
    output logic [WIDTH-1:0]              dout0,
    output logic [WIDTH-1:0]              dout1,
    output logic                          tx_en,
    output logic                          busy,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = 2 * WIDTH;
    localparam int PW = (PREAMBLE_CYCLES > 1) ? $clog2(PREAMBLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    // FIFO storage: {last, data}
    logic [DW:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic [LW-1:0]   level_next_s;
    logic [LW-1:0]   pending_r;
    logic            in_ready_r;

    state_t          state_r;
    logic [PW-1:0]   pre_cnt_r;
    logic [DW-1:0]   dout_r;
    logic            tx_en_r;
    logic            busy_r;
    logic            underrun_r;

    logic            accept_s;
    logic            pop_s;
    logic            empty_s;
    logic            start_s;
    logic [DW:0]     head_s;

    // Handshake, pop decision and next FIFO level.
    always_comb begin
        accept_s = in_if.in_valid && in_ready_r;
        empty_s  = (level_r == {LW{1'b0}});
        head_s   = mem_r[rd_ptr_r];
        // Waiting for tx_en to fall guarantees an idle clock between frames.
        start_s  = !tx_en_r && ((pending_r != {LW{1'b0}}) || (level_r >= LW'(START_THRESH)));
        pop_s    = 1'b0;
        case (state_r)
            // The first word is popped in the last preamble clock so data follows with no gap.
            ST_PREAMBLE: pop_s = (pre_cnt_r == {PW{1'b0}}) && !empty_s;
            ST_DATA:     pop_s = !empty_s;
            ST_DRAIN:    pop_s = !empty_s;
            default:     pop_s = 1'b0;
        endcase
        if (accept_s && !pop_s) begin
            level_next_s = level_r + LW'(1);
        end else if (!accept_s && pop_s) begin
            level_next_s = level_r - LW'(1);
        end else begin
            level_next_s = level_r;
        end
    end

    // FIFO pointers, level, pending-frame count and registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            pending_r  <= {LW{1'b0}};
            in_ready_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r    <= level_next_s;
            in_ready_r <= (level_next_s != LW'(FIFO_DEPTH));
            if ((accept_s && in_if.in_last) && !(pop_s && head_s[DW])) begin
                pending_r <= pending_r + LW'(1);
            end else if (!(accept_s && in_if.in_last) && (pop_s && head_s[DW])) begin
                pending_r <= pending_r - LW'(1);
            end
        end
    end

    // FIFO write port; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= {in_if.in_last, in_if.in_data};
        end
    end

    // Framing state machine with registered lane, strobe and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pre_cnt_r  <= {PW{1'b0}};
            dout_r     <= IDLE_WORD;
            tx_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        // The first preamble clock is driven on entry, so the
                        // counter covers the remaining PREAMBLE_CYCLES-1 clocks.
                        state_r   <= ST_PREAMBLE;
                        pre_cnt_r <= PW'(PREAMBLE_CYCLES - 1);
                        dout_r    <= PREAMBLE_WORD;
                        tx_en_r   <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        dout_r    <= IDLE_WORD;
                        tx_en_r   <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                ST_PREAMBLE, ST_DATA: begin
                    if ((state_r == ST_PREAMBLE) && (pre_cnt_r != {PW{1'b0}})) begin
                        pre_cnt_r <= pre_cnt_r - PW'(1);
                        dout_r    <= PREAMBLE_WORD;
                        tx_en_r   <= 1'b1;
                        busy_r    <= 1'b1;
                    end else if (pop_s) begin
                        dout_r  <= head_s[DW-1:0];
                        tx_en_r <= 1'b1;
                        if (head_s[DW]) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        // Sink cannot stall: running dry mid-frame aborts it.
                        underrun_r <= 1'b1;
                        dout_r     <= IDLE_WORD;
                        tx_en_r    <= 1'b0;
                        state_r    <= ST_DRAIN;
                        busy_r     <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    dout_r  <= IDLE_WORD;
                    tx_en_r <= 1'b0;
                    if (pop_s && head_s[DW]) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    dout_r  <= IDLE_WORD;
                    tx_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_r;
    assign dout0          = dout_r[WIDTH-1:0];
    assign dout1          = dout_r[DW-1:WIDTH];
    assign tx_en          = tx_en_r;
    assign busy           = busy_r;
    assign underrun       = underrun_r;
    assign fifo_level     = level_r;
endmodule
